// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: instruction-memory request/response, control inputs, IF/ID outputs.
// No latency of its own; it only groups wires.
// No backpressure here; stall is carried as a plain level signal.
interface fetch_stage_if;
  logic        stall;
  logic        flush;
  logic        branch_en;
  logic [31:0] branch_target;
  logic        exc_en;
  logic [31:0] inst;
  logic [31:0] inst_address;
  logic        ce;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic        id_valid;
  logic        id_adel;

  // Fetch stage side: consumes control and memory data, produces PC and IF/ID.
  modport master (
    input  stall, flush, branch_en, branch_target, exc_en, inst,
    output inst_address, ce, id_pc, id_inst, id_valid, id_adel
  );

  // Environment side: decode/exception logic and instruction memory.
  modport slave (
    output stall, flush, branch_en, branch_target, exc_en, inst,
    input  inst_address, ce, id_pc, id_inst, id_valid, id_adel
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, drives instruction memory, fills the IF/ID register.
// Latency: the instruction at inst_address lands in IF/ID on the following edge.
// Backpressure: stall holds the PC and IF/ID; a branch seen during stall is parked until release.
module fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0040
) (
  input  logic          clk,
  input  logic          rst,
  fetch_stage_if.master bus
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state;
  logic        ce_q;
  logic [31:0] pc;
  logic        pending_valid;
  logic [31:0] pending_target;
  logic [31:0] id_pc_q;
  logic [31:0] id_inst_q;
  logic        id_valid_q;
  logic        id_adel_q;
  logic        misaligned;

  // Every output comes straight from a register: no input-to-output path.
  assign bus.inst_address = pc;
  assign bus.ce           = ce_q;
  assign bus.id_pc        = id_pc_q;
  assign bus.id_inst      = id_inst_q;
  assign bus.id_valid     = id_valid_q;
  assign bus.id_adel      = id_adel_q;

  assign misaligned = (pc[1:0] != 2'b00);

  // Run-state FSM and next-PC selection, exception first, then branch, stall, parked branch, sequential.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      ce_q           <= 1'b0;
      pc             <= RESET_PC;
      pending_valid  <= 1'b0;
      pending_target <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          // PC is left at RESET_PC so the first enabled fetch uses it.
          state <= RUN;
          ce_q  <= 1'b1;
        end
        RUN: begin
          ce_q <= 1'b1;
          if (bus.exc_en) begin
            pc            <= EXC_VECTOR;
            pending_valid <= 1'b0;
          end else if (bus.branch_en && !bus.stall) begin
            pc            <= bus.branch_target;
            pending_valid <= 1'b0;
          end else if (bus.branch_en) begin
            // Park the redirect; the newest branch wins if several arrive while stalled.
            pending_valid  <= 1'b1;
            pending_target <= bus.branch_target;
          end else if (bus.stall) begin
            pc <= pc;
          end else if (pending_valid) begin
            pc            <= pending_target;
            pending_valid <= 1'b0;
          end else begin
            pc <= pc + 32'd4;
          end
        end
        default: begin
          state <= IDLE;
          ce_q  <= 1'b0;
        end
      endcase
    end
  end

  // IF/ID register: bubble on flush/exception, hold on stall, else capture the fetched word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_pc_q    <= 32'h0;
      id_inst_q  <= 32'h0;
      id_valid_q <= 1'b0;
      id_adel_q  <= 1'b0;
    end else if (!ce_q) begin
      // Not yet fetching: control inputs are ignored and nothing valid is captured.
      id_pc_q    <= pc;
      id_inst_q  <= 32'h0;
      id_valid_q <= 1'b0;
      id_adel_q  <= 1'b0;
    end else if (bus.flush || bus.exc_en) begin
      id_pc_q    <= pc;
      id_inst_q  <= 32'h0;
      id_valid_q <= 1'b0;
      id_adel_q  <= 1'b0;
    end else if (!bus.stall) begin
      // A misaligned fetch becomes a nop tagged with an address error for decode to raise.
      id_pc_q    <= pc;
      id_valid_q <= 1'b1;
      id_adel_q  <= misaligned;
      id_inst_q  <= misaligned ? 32'h0 : bus.inst;
    end
  end

endmodule
